// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Supports software-selected fixed channel or round-robin arbitration.
module stream_mux_rr #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              load_en;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant;
  logic [DATA_W-1:0] grant_data;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    if (!mode) begin
      grant = sel;
      if (32'(sel) < NUM_CH) begin
        grant_vld = in_valid[sel];
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        if (!grant_vld && in_valid[idx[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant     = idx[SEL_W-1:0];
        end
      end
    end
  end

  assign grant_data = DATA_W'(in_data >> (32'(grant) * DATA_W));

  // Held at zero during reset so producers never see a phantom accept.
  assign in_ready = (rst_n && load_en && grant_vld) ? (NUM_CH'(1) << grant) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    if (load_en) begin
      if (grant_vld) begin
        out_data_d  = grant_data;
        out_ch_d    = grant;
        out_valid_d = 1'b1;
        if (mode) begin
          ptr_d = grant;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SEL_W'(NUM_CH - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
